qspi_cmd_sequencer: RTL

Command sequencer between the QSPI slave byte engines (`qspislave_rx` / `qspislave_tx`) and a small internal register bank, all clocked by the design's `useClk` domain. It parses host frames of the form opcode, address, data… and performs register writes or auto-incrementing register reads. It paces the transmit byte stream on the tx engine's `txready` handshake and drives the board LEDs and a control byte from the bank. A frame is bounded by the chip-select (`dcs`) low period; deselect aborts any frame in progress.

---
 rtl/qspi_cmd_sequencer.sv | 92 +++++++++
 1 files changed

// File: rtl/qspi_cmd_sequencer.sv
// qspi_cmd_sequencer: parses QSPI opcode/address/data frames into a register bank (ports: clk, reset_n, ss, rx_data/rx_ready, tx_data/tx_ready, leds, ctrl, err_cnt, busy)
module qspi_cmd_sequencer #(
  parameter int ADDR_W = 4,
  parameter logic [7:0] IDLE_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ss,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [3:0] leds,
  output logic [7:0] ctrl,
  output logic [7:0] err_cnt,
  output logic       busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] RO_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE = 1;
  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, WDATA, RDATA, DISCARD} state_t;
  state_t state;
  logic [7:0] bank [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic is_read;
  logic ss_s1, ss_s2, ss_d;
  logic ss_fall, ss_rise;
  logic [ADDR_W-1:0] rx_addr;
  logic [7:0] rd_ptr, rd_rx;
  assign ss_fall = ss_d & ~ss_s2;
  assign ss_rise = ~ss_d & ss_s2;
  assign rx_addr = rx_data[ADDR_W-1:0];
  assign rd_ptr  = ptr == RO_ADDR ? err_cnt : bank[ptr];
  assign rd_rx   = rx_addr == RO_ADDR ? err_cnt : bank[rx_addr];
  assign leds    = bank[0][3:0];
  assign ctrl    = bank[1];
  assign busy    = state != IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_d    <= 1'b1;
      state   <= IDLE;
      ptr     <= '0;
      is_read <= 1'b0;
      err_cnt <= '0;
      tx_data <= IDLE_BYTE;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      ss_s1 <= ss;
      ss_s2 <= ss_s1;
      ss_d  <= ss_s2;
      if (ss_rise) begin
        state   <= IDLE;
        tx_data <= IDLE_BYTE;
      end else if (ss_fall) begin
        state <= OPCODE;
      end else begin
        case (state)
          OPCODE: if (rx_ready) begin
            if (rx_data == 8'h01 || rx_data == 8'h02) begin
              state   <= ADDR;
              is_read <= rx_data == 8'h02;
            end else begin
              state <= DISCARD;
              if (rx_data != 8'h00 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
          ADDR: if (rx_ready) begin
            if (is_read) begin
              state   <= RDATA;
              tx_data <= rd_rx;
              ptr     <= rx_addr + ONE;
            end else begin
              state <= WDATA;
              ptr   <= rx_addr;
            end
          end
          WDATA: if (rx_ready) begin
            if (ptr != RO_ADDR) bank[ptr] <= rx_data;
            ptr <= ptr + ONE;
          end
          RDATA: if (tx_ready) begin
            tx_data <= rd_ptr;
            ptr     <= ptr + ONE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
